// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch into a small PC/instruction FIFO with redirect flush.
// Optional FETCHQ_BYPASS_EN lets a response reach the output in the cycle it arrives when the FIFO is empty.
module fetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INS_W-1:0]           out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_next;

  logic [PC_W-1:0]  fetch_pc;
  logic             inflight;
  logic [PC_W-1:0]  inflight_pc;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [INS_W-1:0] ins_mem [DEPTH];
  logic             head_valid;
  logic             push;
  logic             fifo_pop;
  logic [CW:0]      occupancy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A redirect always lands in FLUSH, which also restarts an ongoing flush.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    state_next = RUN;
        FLUSH:   state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counting the in-flight fetch guarantees every response has a free slot.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req  = (state == RUN) && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign head_valid = (count != '0);

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    push      = inflight && !redirect;
    if (head_valid) begin
      out_valid = !redirect;
      out_pc    = pc_mem[rd_ptr];
      out_instr = ins_mem[rd_ptr];
    end
`ifdef FETCHQ_BYPASS_EN
    else if (inflight) begin
      out_valid = !redirect;
      out_pc    = inflight_pc;
      out_instr = imem_rdata;
      if (out_ready) push = 1'b0;
    end
`endif
    fifo_pop = head_valid && out_valid && out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + PC_W'(4);
        inflight_pc <= fetch_pc;
      end
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(fifo_pop);
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= inflight_pc;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed timeline with an expected-PC queue checked by a monitor.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int checks;
  int errors;
  logic [8:0] exp_q[$];

  fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [8:0] pc);
    return {16'hC0DE, 7'h00, pc};
  endfunction

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= instr_of(imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [8:0] start, input int n);
    logic [8:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 9'd4;
    end
  endtask

  // Inputs for each cycle of the directed timeline, applied just after the rising edge.
  task automatic applyStimulus(input int cyc);
    case (cyc)
      0:  begin reset = 1'b0; out_ready = 1'b1; pushExpected(9'h000, 10); end
      11: out_ready = 1'b0;
      21: out_ready = 1'b1;
      23: out_ready = 1'b0;
      24: begin redirect = 1'b1; redirect_pc = 9'h040; pushExpected(9'h040, 4); end
      25: begin redirect = 1'b0; out_ready = 1'b1; end
      32: begin redirect = 1'b1; redirect_pc = 9'h080; end
      33: begin redirect_pc = 9'h100; pushExpected(9'h100, 3); end
      34: redirect = 1'b0;
      40: begin redirect = 1'b1; redirect_pc = 9'h1F8; pushExpected(9'h1F8, 5); end
      41: redirect = 1'b0;
      49: out_ready = 1'b0;
      50: reset = 1'b1;
      52: begin reset = 1'b0; out_ready = 1'b1; pushExpected(9'h000, 4); end
      59: out_ready = 1'b0;
      default: ;
    endcase
  endtask

  // Monitor: every accepted head must be the next expected PC with its instruction.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out: got pc 0x%0h expected none", out_pc);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        checkOutput("out_pc", {23'b0, out_pc}, {23'b0, e});
        checkOutput("out_instr", out_instr, instr_of(e));
      end
    end
  end

  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    checks = 0;
    errors = 0;
    #3;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_count", {29'b0, count}, 32'd0);
    checkOutput("rst_out_pc", {23'b0, out_pc}, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 65; cyc++) begin
      applyStimulus(cyc);
      #2;
      case (cyc)
        0:  checkOutput("c0_no_req", {31'b0, imem_req}, 32'd0);
        1:  begin
              checkOutput("c1_req", {31'b0, imem_req}, 32'd1);
              checkOutput("c1_addr", {23'b0, imem_addr}, 32'h000);
            end
        2:  checkOutput("c2_addr", {23'b0, imem_addr}, 32'h004);
        3:  begin
              checkOutput("c3_valid", {31'b0, out_valid}, 32'd1);
              checkOutput("c3_pc", {23'b0, out_pc}, 32'h000);
            end
        21: checkOutput("c21_no_req", {31'b0, imem_req}, 32'd0);
        22: begin
              checkOutput("resume_req", {31'b0, imem_req}, 32'd1);
              checkOutput("resume_addr", {23'b0, imem_addr}, 32'h030);
            end
        24: begin
              checkOutput("redir_count3", {29'b0, count}, 32'd3);
              checkOutput("redir_valid0", {31'b0, out_valid}, 32'd0);
              checkOutput("redir_req0", {31'b0, imem_req}, 32'd0);
            end
        25: checkOutput("flush_req0", {31'b0, imem_req}, 32'd0);
        26: begin
              checkOutput("redir_t2_req", {31'b0, imem_req}, 32'd1);
              checkOutput("redir_t2_addr", {23'b0, imem_addr}, 32'h040);
            end
        27: checkOutput("redir_t3_valid0", {31'b0, out_valid}, 32'd0);
        28: begin
              checkOutput("redir_t4_valid", {31'b0, out_valid}, 32'd1);
              checkOutput("redir_t4_pc", {23'b0, out_pc}, 32'h040);
            end
        35: checkOutput("b2b_addr", {23'b0, imem_addr}, 32'h100);
        44: checkOutput("wrap_issue", {23'b0, imem_addr}, 32'h000);
        50: begin
              checkOutput("async_valid", {31'b0, out_valid}, 32'd0);
              checkOutput("async_req", {31'b0, imem_req}, 32'd0);
              checkOutput("async_count", {29'b0, count}, 32'd0);
              checkOutput("async_pc", {23'b0, out_pc}, 32'd0);
              checkOutput("async_instr", out_instr, 32'd0);
            end
        53: begin
              checkOutput("rst2_req", {31'b0, imem_req}, 32'd1);
              checkOutput("rst2_addr", {23'b0, imem_addr}, 32'h000);
            end
        default: ;
      endcase
      if (cyc >= 3 && cyc <= 10)
        checkOutput("flow_count_le2", {31'b0, (count <= 3'd2)}, 32'd1);
      if (cyc >= 14 && cyc <= 20) begin
        checkOutput("stall_count4", {29'b0, count}, 32'd4);
        checkOutput("stall_no_req", {31'b0, imem_req}, 32'd0);
        checkOutput("stall_pc_hold", {23'b0, out_pc}, 32'h020);
        checkOutput("stall_instr_hold", out_instr, instr_of(9'h020));
      end
      @(posedge clk);
      #1;
    end
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
